// File: rtl/vend_pkg.sv
// Shared definitions for the multi-slot vending controller: coin encodings,
// controller states and the coin denomination helpers.
package vend_pkg;

  localparam logic [2:0] COIN_5   = 3'd0;
  localparam logic [2:0] COIN_10  = 3'd1;
  localparam logic [2:0] COIN_25  = 3'd2;
  localparam logic [2:0] COIN_50  = 3'd3;
  localparam logic [2:0] COIN_100 = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CREDIT,
    ST_VEND,
    ST_CHANGE
  } state_e;

  // Cents for a coin code; codes 5..7 are not coins and are worth nothing.
  function automatic logic [7:0] coin_value(input logic [2:0] code);
    case (code)
      COIN_5:   return 8'd5;
      COIN_10:  return 8'd10;
      COIN_25:  return 8'd25;
      COIN_50:  return 8'd50;
      COIN_100: return 8'd100;
      default:  return 8'd0;
    endcase
  endfunction

  // Greedy choice: the largest denomination that does not exceed amt.
  function automatic logic [2:0] largest_coin(input logic [31:0] amt);
    if (amt >= 32'd100)     return COIN_100;
    else if (amt >= 32'd50) return COIN_50;
    else if (amt >= 32'd25) return COIN_25;
    else if (amt >= 32'd10) return COIN_10;
    else                    return COIN_5;
  endfunction

endpackage

// File: rtl/vend_change_unit.sv
// Greedy change dispenser: loads an amount, offers one coin at a time on a
// ready/valid handshake and flags the transfer that empties the amount.
module vend_change_unit
  import vend_pkg::*;
#(
  parameter int AMT_W = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [AMT_W-1:0] load_amt,
  input  logic             coin_out_ready,
  output logic             coin_out_valid,
  output logic [2:0]       coin_out_code,
  output logic [AMT_W-1:0] amt_next,
  output logic             done
);

  logic [AMT_W-1:0] amt_q, amt_d;
  logic             valid_q, valid_d;
  logic [2:0]       code_q, code_d;

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    amt_next = amt_q;
    if (valid_q && coin_out_ready) begin
      amt_next = amt_q - AMT_W'(coin_value(code_q));
    end
    done    = valid_q && coin_out_ready && (amt_next == '0);
    amt_d   = load ? load_amt : amt_next;
    valid_d = (amt_d != '0);
    // Code is recomputed from an unchanged amount while stalled, so it holds.
    code_d  = valid_d ? largest_coin(32'(amt_d)) : COIN_5;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      amt_q   <= '0;
      valid_q <= 1'b0;
      code_q  <= COIN_5;
    end else begin
      amt_q   <= amt_d;
      valid_q <= valid_d;
      code_q  <= code_d;
    end
  end

  assign coin_out_valid = valid_q;
  assign coin_out_code  = code_q;

endmodule

// File: rtl/vend_ctrl_multi.sv
// Multi-slot vending controller: credit FSM, price/stock tables, inactivity
// timeout and hand-off to the change dispenser. All outputs are registered.
module vend_ctrl_multi
  import vend_pkg::*;
#(
  parameter int NUM_SLOTS   = 8,
  parameter int SEL_W       = $clog2(NUM_SLOTS),
  parameter int AMT_W       = 10,
  parameter int MAX_CREDIT  = 500,
  parameter int STOCK_W     = 4,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               coin_valid,
  input  logic [2:0]         coin_code,
  input  logic               sel_valid,
  input  logic [SEL_W-1:0]   sel_idx,
  input  logic               cancel,
  input  logic               price_we,
  input  logic [SEL_W-1:0]   price_idx,
  input  logic [AMT_W-1:0]   price_data,
  input  logic               restock_we,
  input  logic [SEL_W-1:0]   restock_idx,
  input  logic [STOCK_W-1:0] restock_qty,
  input  logic               coin_out_ready,
  output logic [AMT_W-1:0]   credit,
  output logic               coin_reject,
  output logic               vend_valid,
  output logic [SEL_W-1:0]   vend_idx,
  output logic               sold_out,
  output logic               insufficient,
  output logic               coin_out_valid,
  output logic [2:0]         coin_out_code,
  output logic               busy
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [SEL_W:0] NUM_SLOTS_W = (SEL_W + 1)'(NUM_SLOTS);

  state_e             state_q, state_d;
  logic [AMT_W-1:0]   credit_q, credit_d;
  logic [AMT_W-1:0]   price_q [NUM_SLOTS];
  logic [AMT_W-1:0]   price_d [NUM_SLOTS];
  logic [STOCK_W-1:0] stock_q [NUM_SLOTS];
  logic [STOCK_W-1:0] stock_d [NUM_SLOTS];
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SEL_W-1:0]   vend_idx_q, vend_idx_d;
  logic [AMT_W-1:0]   vend_price_q, vend_price_d;
  logic               coin_reject_q, coin_reject_d;
  logic               vend_valid_q, vend_valid_d;
  logic               sold_out_q, sold_out_d;
  logic               insufficient_q, insufficient_d;
  logic               busy_q, busy_d;

  logic [AMT_W-1:0]   coin_val, sel_price, chg_amt, chg_amt_next;
  logic [STOCK_W-1:0] sel_stock;
  logic               coin_ok, sel_in_range, chg_load, chg_done;

  // NOTE: always_comb uses blocking '=' so later statements see earlier
  // results (e.g. credit_d in VEND); flops take only non-blocking '<='.
  always_comb begin
    state_d        = state_q;
    credit_d       = credit_q;
    price_d        = price_q;
    stock_d        = stock_q;
    cnt_d          = cnt_q;
    vend_idx_d     = vend_idx_q;
    vend_price_d   = vend_price_q;
    coin_reject_d  = 1'b0;
    vend_valid_d   = 1'b0;
    sold_out_d     = 1'b0;
    insufficient_d = 1'b0;
    chg_load       = 1'b0;
    chg_amt        = credit_q;

    coin_val     = AMT_W'(coin_value(coin_code));
    coin_ok      = (coin_val != '0) &&
                   (({1'b0, credit_q} + {1'b0, coin_val}) <= (AMT_W + 1)'(MAX_CREDIT));
    sel_in_range = ({1'b0, sel_idx} < NUM_SLOTS_W);
    sel_price    = '0;
    sel_stock    = '0;
    if (sel_in_range) begin
      sel_price = price_q[sel_idx];
      sel_stock = stock_q[sel_idx];
    end

    case (state_q)
      ST_IDLE: begin
        if (coin_valid) begin
          if (coin_ok) begin
            credit_d = credit_q + coin_val;
            state_d  = ST_CREDIT;
            cnt_d    = '0;
          end else begin
            coin_reject_d = 1'b1;
          end
        end
      end
      // Same-cycle priority: cancel, then selection, then coin.
      ST_CREDIT: begin
        if (cancel) begin
          coin_reject_d = coin_valid;
          state_d       = ST_CHANGE;
          chg_load      = 1'b1;
        end else if (sel_valid) begin
          coin_reject_d = coin_valid;
          cnt_d         = '0;
          if (!sel_in_range || sel_stock == '0 || sel_price == '0) begin
            sold_out_d = 1'b1;
          end else if (credit_q < sel_price) begin
            insufficient_d = 1'b1;
          end else begin
            state_d      = ST_VEND;
            vend_valid_d = 1'b1;
            vend_idx_d   = sel_idx;
            vend_price_d = sel_price;
          end
        end else if (coin_valid && coin_ok) begin
          credit_d = credit_q + coin_val;
          cnt_d    = '0;
        end else begin
          coin_reject_d = coin_valid;
          if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
            state_d  = ST_CHANGE;
            chg_load = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_VEND: begin
        coin_reject_d = coin_valid;
        credit_d      = credit_q - vend_price_q;
        if (stock_q[vend_idx_q] != '0) begin
          stock_d[vend_idx_q] = stock_q[vend_idx_q] - STOCK_W'(1);
        end
        if (credit_d != '0) begin
          state_d  = ST_CHANGE;
          chg_load = 1'b1;
          chg_amt  = credit_d;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CHANGE: begin
        coin_reject_d = coin_valid;
        credit_d      = chg_amt_next;
        if (chg_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Applied after the vend decrement so a same-cycle restock wins.
    if (price_we && ({1'b0, price_idx} < NUM_SLOTS_W)) begin
      price_d[price_idx] = price_data;
    end
    if (restock_we && ({1'b0, restock_idx} < NUM_SLOTS_W)) begin
      stock_d[restock_idx] = restock_qty;
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      credit_q       <= '0;
      // NOTE: the tables are small flop arrays, not RAM, and must read as
      // empty after reset, so they are cleared like any other register.
      price_q        <= '{default: '0};
      stock_q        <= '{default: '0};
      cnt_q          <= '0;
      vend_idx_q     <= '0;
      vend_price_q   <= '0;
      coin_reject_q  <= 1'b0;
      vend_valid_q   <= 1'b0;
      sold_out_q     <= 1'b0;
      insufficient_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      credit_q       <= credit_d;
      price_q        <= price_d;
      stock_q        <= stock_d;
      cnt_q          <= cnt_d;
      vend_idx_q     <= vend_idx_d;
      vend_price_q   <= vend_price_d;
      coin_reject_q  <= coin_reject_d;
      vend_valid_q   <= vend_valid_d;
      sold_out_q     <= sold_out_d;
      insufficient_q <= insufficient_d;
      busy_q         <= busy_d;
    end
  end

  vend_change_unit #(
    .AMT_W (AMT_W)
  ) u_change (
    .clk            (clk),
    .reset          (reset),
    .load           (chg_load),
    .load_amt       (chg_amt),
    .coin_out_ready (coin_out_ready),
    .coin_out_valid (coin_out_valid),
    .coin_out_code  (coin_out_code),
    .amt_next       (chg_amt_next),
    .done           (chg_done)
  );

  assign credit       = credit_q;
  assign coin_reject  = coin_reject_q;
  assign vend_valid   = vend_valid_q;
  assign vend_idx     = vend_idx_q;
  assign sold_out     = sold_out_q;
  assign insufficient = insufficient_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_vend_ctrl_multi.sv
// Bench for vend_ctrl_multi: directed scenarios with fixed expectations, then
// randomized traffic against a transaction-level model of the vending rules.
module tb_vend_ctrl_multi;

  localparam int T       = 50;
  localparam int MAX_CR  = 500;

  logic       clk = 1'b0;
  logic       reset, coin_valid, sel_valid, cancel, price_we, restock_we, coin_out_ready;
  logic [2:0] coin_code, sel_idx, price_idx, restock_idx;
  logic [9:0] price_data;
  logic [3:0] restock_qty;
  logic [9:0] credit;
  logic       coin_reject, vend_valid, sold_out, insufficient, coin_out_valid, busy;
  logic [2:0] vend_idx, coin_out_code;

  int checks = 0;
  int errors = 0;

  vend_ctrl_multi #(
    .NUM_SLOTS(8), .AMT_W(10), .MAX_CREDIT(MAX_CR), .STOCK_W(4), .TIMEOUT_CYC(T)
  ) dut (
    .clk(clk), .reset(reset), .coin_valid(coin_valid), .coin_code(coin_code),
    .sel_valid(sel_valid), .sel_idx(sel_idx), .cancel(cancel),
    .price_we(price_we), .price_idx(price_idx), .price_data(price_data),
    .restock_we(restock_we), .restock_idx(restock_idx), .restock_qty(restock_qty),
    .coin_out_ready(coin_out_ready), .credit(credit), .coin_reject(coin_reject),
    .vend_valid(vend_valid), .vend_idx(vend_idx), .sold_out(sold_out),
    .insufficient(insufficient), .coin_out_valid(coin_out_valid),
    .coin_out_code(coin_out_code), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference model: machine phase, credit in cents, tables, and the list of
  // change coins still owed (worked out greedily when change starts).
  localparam int PH_IDLE = 0, PH_CREDIT = 1, PH_VEND = 2, PH_CHANGE = 3;
  int   m_phase, m_credit, m_idle, m_vslot, m_vprice;
  int   m_price [8];
  int   m_stock [8];
  int   m_owed [$];
  logic e_reject, e_vend, e_sold, e_insuf, e_cov, e_busy;
  logic [2:0] e_vidx, e_cod;

  function automatic int cents(input int code);
    case (code)
      0: return 5;
      1: return 10;
      2: return 25;
      3: return 50;
      4: return 100;
      default: return 0;
    endcase
  endfunction

  task automatic start_change(input int amt);
    int denom [5] = '{100, 50, 25, 10, 5};
    int code  [5] = '{4, 3, 2, 1, 0};
    m_owed.delete();
    for (int i = 0; i < 5; i++) begin
      while (amt >= denom[i]) begin
        m_owed.push_back(code[i]);
        amt -= denom[i];
      end
    end
    m_phase = PH_CHANGE;
  endtask

  task automatic model_step();
    int v;
    int s;
    bit ok;
    if (reset) begin
      m_phase = PH_IDLE; m_credit = 0; m_idle = 0; m_owed.delete();
      for (int i = 0; i < 8; i++) begin m_price[i] = 0; m_stock[i] = 0; end
      {e_reject, e_vend, e_sold, e_insuf, e_cov, e_busy, e_vidx, e_cod} = '0;
      return;
    end
    {e_reject, e_vend, e_sold, e_insuf} = '0;
    v  = cents(int'(coin_code));
    ok = coin_valid && v > 0 && (m_credit + v) <= MAX_CR;
    case (m_phase)
      PH_IDLE:
        if (coin_valid) begin
          if (ok) begin m_credit += v; m_phase = PH_CREDIT; m_idle = 0; end
          else e_reject = 1'b1;
        end
      PH_CREDIT:
        if (cancel) begin
          e_reject = coin_valid;
          start_change(m_credit);
        end else if (sel_valid) begin
          e_reject = coin_valid;
          m_idle   = 0;
          s        = int'(sel_idx);
          if (m_stock[s] == 0 || m_price[s] == 0) e_sold = 1'b1;
          else if (m_credit < m_price[s]) e_insuf = 1'b1;
          else begin
            m_phase = PH_VEND; e_vend = 1'b1; e_vidx = sel_idx;
            m_vslot = s; m_vprice = m_price[s];
          end
        end else if (ok) begin
          m_credit += v;
          m_idle = 0;
        end else begin
          e_reject = coin_valid;
          m_idle++;
          if (m_idle == T) start_change(m_credit);
        end
      PH_VEND: begin
        e_reject = coin_valid;
        m_credit -= m_vprice;
        if (m_stock[m_vslot] > 0) m_stock[m_vslot]--;
        if (m_credit > 0) start_change(m_credit);
        else m_phase = PH_IDLE;
      end
      default: begin
        e_reject = coin_valid;
        if (coin_out_ready) begin
          m_credit -= cents(m_owed.pop_front());
          if (m_owed.size() == 0) m_phase = PH_IDLE;
        end
      end
    endcase
    if (price_we) m_price[price_idx] = int'(price_data);
    if (restock_we) m_stock[restock_idx] = int'(restock_qty);
    e_cov  = (m_phase == PH_CHANGE);
    e_cod  = e_cov ? 3'(m_owed[0]) : 3'd0;
    e_busy = (m_phase != PH_IDLE);
  endtask

  // One clock: DUT and model both take the edge, outputs are read 1 ns later.
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic clear_inputs();
    reset = 0; coin_valid = 0; coin_code = 0; sel_valid = 0; sel_idx = 0; cancel = 0;
    price_we = 0; price_idx = 0; price_data = 0; restock_we = 0; restock_idx = 0;
    restock_qty = 0; coin_out_ready = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1;
    cycle();
    cycle();
    reset = 0;
  endtask

  task automatic put_coin(input logic [2:0] c);
    coin_valid = 1; coin_code = c;
    cycle();
    coin_valid = 0;
  endtask

  task automatic set_slot(input int s, input int price, input int qty);
    price_we = 1; price_idx = 3'(s); price_data = 10'(price);
    restock_we = 1; restock_idx = 3'(s); restock_qty = 4'(qty);
    cycle();
    price_we = 0; restock_we = 0;
  endtask

  task automatic select(input int s);
    sel_valid = 1; sel_idx = 3'(s);
    cycle();
    sel_valid = 0;
  endtask

  task automatic do_cancel();
    cancel = 1;
    cycle();
    cancel = 0;
  endtask

  // Accept change coins until the controller goes idle, within a cycle budget.
  task automatic drain(input string tag);
    coin_out_ready = 1;
    for (int i = 0; i < 40 && busy; i++) cycle();
    coin_out_ready = 0;
    checks++;
    if (busy !== 1'b0 || credit !== 10'd0) begin
      errors++;
      $display("FAIL %s_drain busy=%b credit=%0d required busy=0 credit=0", tag, busy, credit);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (credit !== 10'd0 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_state credit=%0d busy=%b required 0/0", credit, busy);
    end
    checks++;
    if ({coin_reject, vend_valid, sold_out, insufficient} !== 4'b0) begin
      errors++; $display("FAIL reset_pulses got=%b required 0000",
                         {coin_reject, vend_valid, sold_out, insufficient});
    end
    checks++;
    if (coin_out_valid !== 1'b0 || coin_out_code !== 3'd0 || vend_idx !== 3'd0) begin
      errors++; $display("FAIL reset_coin_out valid=%b code=%0d vend_idx=%0d required 0/0/0",
                         coin_out_valid, coin_out_code, vend_idx);
    end
  endtask

  task automatic test_vend_change();
    do_reset();
    set_slot(2, 65, 3);
    put_coin(3'd3);
    checks++;
    if (credit !== 10'd50 || busy !== 1'b1) begin
      errors++; $display("FAIL vend_first_coin credit=%0d busy=%b required 50/1", credit, busy);
    end
    put_coin(3'd2);
    checks++;
    if (credit !== 10'd75) begin
      errors++; $display("FAIL vend_second_coin credit=%0d required 75", credit);
    end
    select(2);
    checks++;
    if (vend_valid !== 1'b1 || vend_idx !== 3'd2 || coin_out_valid !== 1'b0) begin
      errors++; $display("FAIL vend_pulse vend_valid=%b vend_idx=%0d cov=%b required 1/2/0",
                         vend_valid, vend_idx, coin_out_valid);
    end
    cycle();
    checks++;
    if (vend_valid !== 1'b0 || coin_out_valid !== 1'b1 || coin_out_code !== 3'd1 || credit !== 10'd10) begin
      errors++; $display("FAIL vend_change_coin vv=%b cov=%b code=%0d credit=%0d required 0/1/1/10",
                         vend_valid, coin_out_valid, coin_out_code, credit);
    end
    checks++;
    if (dut.stock_q[2] !== 4'd2) begin
      errors++; $display("FAIL vend_stock got=%0d required 2", dut.stock_q[2]);
    end
    coin_out_ready = 1;
    cycle();
    coin_out_ready = 0;
    checks++;
    if (credit !== 10'd0 || coin_out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL vend_back_to_idle credit=%0d cov=%b busy=%b required 0/0/0",
                         credit, coin_out_valid, busy);
    end
  endtask

  task automatic test_cancel_hold();
    logic [2:0] want_code [3] = '{3'd1, 3'd0, 3'd0};
    int         want_cr   [3] = '{15, 5, 0};
    do_reset();
    put_coin(3'd2); put_coin(3'd1); put_coin(3'd0);
    do_cancel();
    checks++;
    if (coin_out_valid !== 1'b1 || coin_out_code !== 3'd2 || credit !== 10'd40) begin
      errors++; $display("FAIL cancel_first_coin cov=%b code=%0d credit=%0d required 1/2/40",
                         coin_out_valid, coin_out_code, credit);
    end
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if (coin_out_valid !== 1'b1 || coin_out_code !== 3'd2 || credit !== 10'd40) begin
        errors++; $display("FAIL cancel_stall%0d cov=%b code=%0d credit=%0d required 1/2/40",
                           i, coin_out_valid, coin_out_code, credit);
      end
    end
    coin_out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if (credit !== 10'(want_cr[i]) || coin_out_valid !== (want_cr[i] != 0) ||
          (want_cr[i] != 0 && coin_out_code !== want_code[i])) begin
        errors++; $display("FAIL cancel_transfer%0d cov=%b code=%0d credit=%0d required credit %0d code %0d",
                           i, coin_out_valid, coin_out_code, credit, want_cr[i], want_code[i]);
      end
    end
    coin_out_ready = 0;
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL cancel_idle busy=%b required 0", busy);
    end
  endtask

  task automatic test_sold_out_insufficient();
    do_reset();
    set_slot(5, 40, 0);
    set_slot(3, 50, 5);
    put_coin(3'd2); put_coin(3'd0);
    select(5);
    checks++;
    if (sold_out !== 1'b1 || insufficient !== 1'b0 || busy !== 1'b1 || credit !== 10'd30) begin
      errors++; $display("FAIL sold_out_pulse so=%b ins=%b busy=%b credit=%0d required 1/0/1/30",
                         sold_out, insufficient, busy, credit);
    end
    cycle();
    checks++;
    if (sold_out !== 1'b0) begin
      errors++; $display("FAIL sold_out_one_cycle so=%b required 0", sold_out);
    end
    select(3);
    checks++;
    if (insufficient !== 1'b1 || vend_valid !== 1'b0 || credit !== 10'd30) begin
      errors++; $display("FAIL insufficient_pulse ins=%b vv=%b credit=%0d required 1/0/30",
                         insufficient, vend_valid, credit);
    end
    do_cancel();
    drain("insufficient");
    put_coin(3'd3);
    select(3);
    cycle();
    checks++;
    if (busy !== 1'b0 || coin_out_valid !== 1'b0 || credit !== 10'd0) begin
      errors++; $display("FAIL exact_price busy=%b cov=%b credit=%0d required 0/0/0",
                         busy, coin_out_valid, credit);
    end
  endtask

  task automatic test_max_credit();
    do_reset();
    repeat (4) put_coin(3'd4);
    put_coin(3'd3);
    put_coin(3'd4);
    checks++;
    if (coin_reject !== 1'b1 || credit !== 10'd450) begin
      errors++; $display("FAIL max_over_reject rej=%b credit=%0d required 1/450", coin_reject, credit);
    end
    put_coin(3'd6);
    checks++;
    if (coin_reject !== 1'b1 || credit !== 10'd450) begin
      errors++; $display("FAIL invalid_code_reject rej=%b credit=%0d required 1/450", coin_reject, credit);
    end
    put_coin(3'd3);
    checks++;
    if (coin_reject !== 1'b0 || credit !== 10'd500) begin
      errors++; $display("FAIL max_exact_accept rej=%b credit=%0d required 0/500", coin_reject, credit);
    end
    put_coin(3'd0);
    checks++;
    if (coin_reject !== 1'b1 || credit !== 10'd500) begin
      errors++; $display("FAIL max_full_reject rej=%b credit=%0d required 1/500", coin_reject, credit);
    end
    do_cancel();
    drain("max_credit");
  endtask

  task automatic test_timeout();
    do_reset();
    put_coin(3'd2);
    repeat (T - 1) cycle();
    checks++;
    if (coin_out_valid !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL timeout_early cov=%b busy=%b required 0/1", coin_out_valid, busy);
    end
    cycle();
    checks++;
    if (coin_out_valid !== 1'b1 || coin_out_code !== 3'd2 || credit !== 10'd25) begin
      errors++; $display("FAIL timeout_refund cov=%b code=%0d credit=%0d required 1/2/25",
                         coin_out_valid, coin_out_code, credit);
    end
    drain("timeout");
    put_coin(3'd2);
    repeat (T - 2) cycle();
    put_coin(3'd0);
    repeat (T - 1) cycle();
    checks++;
    if (coin_out_valid !== 1'b0) begin
      errors++; $display("FAIL timeout_restart cov=%b required 0", coin_out_valid);
    end
    cycle();
    checks++;
    if (coin_out_valid !== 1'b1 || credit !== 10'd30) begin
      errors++; $display("FAIL timeout_second cov=%b credit=%0d required 1/30", coin_out_valid, credit);
    end
    drain("timeout2");
  endtask

  task automatic test_priority();
    do_reset();
    set_slot(1, 10, 1);
    put_coin(3'd2);
    cancel = 1; sel_valid = 1; sel_idx = 3'd1; coin_valid = 1; coin_code = 3'd0;
    cycle();
    clear_inputs();
    checks++;
    if (coin_reject !== 1'b1 || vend_valid !== 1'b0 || coin_out_valid !== 1'b1 ||
        coin_out_code !== 3'd2 || credit !== 10'd25) begin
      errors++; $display("FAIL prio_cancel rej=%b vv=%b cov=%b code=%0d credit=%0d required 1/0/1/2/25",
                         coin_reject, vend_valid, coin_out_valid, coin_out_code, credit);
    end
    drain("prio_cancel");
    put_coin(3'd2);
    sel_valid = 1; sel_idx = 3'd1; coin_valid = 1; coin_code = 3'd0;
    cycle();
    clear_inputs();
    checks++;
    if (coin_reject !== 1'b1 || vend_valid !== 1'b1 || credit !== 10'd25) begin
      errors++; $display("FAIL prio_select rej=%b vv=%b credit=%0d required 1/1/25",
                         coin_reject, vend_valid, credit);
    end
    cycle();
    drain("prio_select");
    do_cancel();
    checks++;
    if (busy !== 1'b0 || coin_out_valid !== 1'b0) begin
      errors++; $display("FAIL cancel_in_idle busy=%b cov=%b required 0/0", busy, coin_out_valid);
    end
  endtask

  task automatic test_reset_mid_change();
    do_reset();
    set_slot(4, 10, 2);
    put_coin(3'd2); put_coin(3'd1);
    do_cancel();
    reset = 1;
    cycle();
    reset = 0;
    checks++;
    if ({credit, coin_reject, vend_valid, vend_idx, sold_out, insufficient,
         coin_out_valid, coin_out_code, busy} !== 22'd0) begin
      errors++; $display("FAIL reset_mid_change credit=%0d cov=%b code=%0d busy=%b required all 0",
                         credit, coin_out_valid, coin_out_code, busy);
    end
    put_coin(3'd2);
    select(4);
    checks++;
    if (sold_out !== 1'b1 || vend_valid !== 1'b0) begin
      errors++; $display("FAIL reset_clears_tables so=%b vv=%b required 1/0", sold_out, vend_valid);
    end
    do_cancel();
    drain("reset_mid");
  endtask

  task automatic test_random();
    logic [21:0] act, exp;
    bit quiet;
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      quiet       = ((n / 400) % 3) == 2;
      reset       = ($urandom_range(0, 999) == 0);
      coin_valid  = $urandom_range(0, 99) < (quiet ? 2 : 30);
      coin_code   = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      sel_valid   = $urandom_range(0, 99) < (quiet ? 1 : 12);
      sel_idx     = 3'($urandom);
      cancel      = $urandom_range(0, 99) < (quiet ? 0 : 3);
      price_we    = ($urandom_range(0, 99) < 6) && !sel_valid && (m_phase != PH_VEND);
      price_idx   = 3'($urandom);
      price_data  = 10'(5 * $urandom_range(0, 30));
      restock_we  = $urandom_range(0, 99) < 6;
      restock_idx = 3'($urandom);
      restock_qty = 4'($urandom);
      coin_out_ready = $urandom_range(0, 99) < 60;
      cycle();
      act = {credit, coin_reject, vend_valid, vend_idx, sold_out, insufficient,
             coin_out_valid, coin_out_code, busy};
      exp = {10'(m_credit), e_reject, e_vend, e_vidx, e_sold, e_insuf, e_cov, e_cod, e_busy};
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL random cyc=%0d got credit=%0d rej=%b vv=%b vidx=%0d so=%b ins=%b cov=%b code=%0d busy=%b required %h got %h",
                 n, credit, coin_reject, vend_valid, vend_idx, sold_out, insufficient,
                 coin_out_valid, coin_out_code, busy, exp, act);
      end
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_vend_change();
    test_cancel_hold();
    test_sold_out_insufficient();
    test_max_credit();
    test_timeout();
    test_priority();
    test_reset_mid_change();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
